// File: rtl/ram_access_arbiter.sv
// Two-port arbiter/sequencer for the 64x1 bit-addressable RAM: 17-bit window or
// bit-serial reads, bit-serial writes and whole-RAM clear, round-robin between ports.
module ram_access_arbiter (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        p0_req,
    input  logic [5:0]  p0_addr,
    output logic        p0_ack,
    output logic [16:0] p0_rdata,
    input  logic        p1_req,
    input  logic [1:0]  p1_op,
    input  logic [5:0]  p1_addr,
    input  logic [4:0]  p1_len,
    input  logic [16:0] p1_wdata,
    output logic        p1_ack,
    output logic [16:0] p1_rdata,
    output logic        p1_err,
    output logic [5:0]  ram_address,
    output logic        ram_datain,
    output logic        ram_store,
    output logic        ram_clear,
    input  logic        ram_dataout,
    input  logic [16:0] ram_window
);
    localparam int unsigned AW = 6;
    localparam int unsigned DW = 17;
    localparam int unsigned KW = 5;
    localparam int unsigned LW = 5;
    localparam logic [AW-1:0] WIN_MAX_BASE = AW'(47);
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_WIN_RD, S_SER_RD, S_WR, S_CLR, S_ACK} state_t;

    state_t        r_state, w_state_nxt;
    logic [KW-1:0] r_k, w_k_nxt;
    logic          r_last, r_port, w_port_nxt;
    logic [AW-1:0] r_base, w_base_nxt;
    logic [LW-1:0] r_len, w_len_nxt;
    logic [DW-1:0] r_wdata, w_wdata_nxt;
    logic          r_err, w_err_nxt;
    logic [DW-2:0] r_shift;
    logic [DW-1:0] w_rd_word;
    logic          w_rd_done;
    logic [KW-1:0] w_bit_idx;
    logic [AW-1:0] w_addr_nxt;
    logic          w_store_nxt, w_datain_nxt, w_clear_nxt;
    logic          w_p0_ack_nxt, w_p1_ack_nxt, w_p1_err_nxt;

    // State register; RAM-side and port outputs are registered from next-state decode
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_last      <= 1'b1;
            r_port      <= 1'b0;
            r_base      <= '0;
            r_len       <= '0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_shift     <= '0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
            p0_ack      <= 1'b0;
            p1_ack      <= 1'b0;
            p1_err      <= 1'b0;
            ram_address <= '0;
            ram_datain  <= 1'b0;
            ram_store   <= 1'b0;
            ram_clear   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_port      <= w_port_nxt;
            r_base      <= w_base_nxt;
            r_len       <= w_len_nxt;
            r_wdata     <= w_wdata_nxt;
            r_err       <= w_err_nxt;
            p0_ack      <= w_p0_ack_nxt;
            p1_ack      <= w_p1_ack_nxt;
            p1_err      <= w_p1_err_nxt;
            ram_address <= w_addr_nxt;
            ram_datain  <= w_datain_nxt;
            ram_store   <= w_store_nxt;
            ram_clear   <= w_clear_nxt;
            if (r_state == S_ACK) r_last <= r_port;
            if (r_state == S_SER_RD) r_shift <= {r_shift[DW-3:0], ram_dataout};
            if (w_rd_done) begin
                if (r_port) p1_rdata <= w_rd_word;
                else        p0_rdata <= w_rd_word;
            end
        end
    end

    // Next-state: arbitration and dispatch in IDLE, sequencing counter elsewhere
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_port_nxt  = r_port;
        w_base_nxt  = r_base;
        w_len_nxt   = r_len;
        w_wdata_nxt = r_wdata;
        w_err_nxt   = r_err;
        unique case (r_state)
            S_IDLE: begin
                if (p0_req || p1_req) begin
                    w_port_nxt = p1_req && (!p0_req || !r_last);
                    w_k_nxt    = '0;
                    w_err_nxt  = 1'b0;
                    if (!w_port_nxt) begin
                        w_base_nxt  = p0_addr;
                        w_state_nxt = (p0_addr <= WIN_MAX_BASE) ? S_WIN_RD : S_SER_RD;
                    end else begin
                        w_base_nxt  = p1_addr;
                        w_len_nxt   = p1_len;
                        w_wdata_nxt = p1_wdata;
                        if (p1_op == OP_READ) begin
                            w_state_nxt = (p1_addr <= WIN_MAX_BASE) ? S_WIN_RD : S_SER_RD;
                        end else if (p1_op == OP_WRITE && p1_len != '0 && p1_len <= LW'(DW)) begin
                            w_state_nxt = S_WR;
                        end else if (p1_op == OP_CLEAR) begin
                            w_state_nxt = S_CLR;
                        end else begin
                            w_state_nxt = S_ACK;
                            w_err_nxt   = 1'b1;
                        end
                    end
                end
            end
            S_WIN_RD: w_state_nxt = S_ACK;
            S_SER_RD: begin
                if (r_k == KW'(DW-1)) w_state_nxt = S_ACK;
                else                  w_k_nxt     = r_k + KW'(1);
            end
            S_WR: begin
                if (r_k == r_len - LW'(1)) w_state_nxt = S_ACK;
                else                       w_k_nxt     = r_k + KW'(1);
            end
            S_CLR: w_state_nxt = S_ACK;
            S_ACK: begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = '0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state so every output leaves a flop
    always_comb begin
        w_addr_nxt   = w_base_nxt;
        w_store_nxt  = 1'b0;
        w_datain_nxt = 1'b0;
        w_clear_nxt  = 1'b0;
        w_p0_ack_nxt = 1'b0;
        w_p1_ack_nxt = 1'b0;
        w_p1_err_nxt = 1'b0;
        w_bit_idx    = KW'(DW-1) - w_k_nxt;
        if (w_state_nxt == S_SER_RD || w_state_nxt == S_WR)
            w_addr_nxt = w_base_nxt + AW'(w_k_nxt);
        if (w_state_nxt == S_WR) begin
            w_store_nxt  = 1'b1;
            w_datain_nxt = w_wdata_nxt[w_bit_idx];
        end
        if (w_state_nxt == S_CLR) w_clear_nxt = 1'b1;
        if (w_state_nxt == S_ACK) begin
            w_p0_ack_nxt = !w_port_nxt;
            w_p1_ack_nxt = w_port_nxt;
            w_p1_err_nxt = w_port_nxt && w_err_nxt;
        end
    end

    // Read word: window capture, or the gathered bits plus the final serial bit
    always_comb begin
        w_rd_word = (r_state == S_WIN_RD) ? ram_window : {r_shift, ram_dataout};
        w_rd_done = (r_state == S_WIN_RD) || (r_state == S_SER_RD && r_k == KW'(DW-1));
    end
endmodule
